serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 op_a  input  WIDTH  addend A; captured when start is accepted.
REQ-006 op_b  input  WIDTH  addend B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 fa_a  output  1  bit to external full adder input a.
REQ-009 fa_b  output  1  bit to external full adder input b.
REQ-010 fa_cin  output  1  carry to external full adder input cin.
REQ-011 fa_sum  input  1  sum from external full adder (combinational).
REQ-012 fa_cout  input  1  carry-out from external full adder (combinational).
REQ-013 busy  output  1  high while an addition is in progress.
REQ-014 done  output  1  one-cycle pulse: sum and cout valid.
REQ-015 sum  output  WIDTH  result, held until next accepted start.
REQ-016 cout  output  1  final carry-out, held until next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-018 IDLE: start=1 at a rising edge SHALL load A/B shift registers from op_a/op_b, carry register from cin, bit counter to 0, and go to RUN.
REQ-019 RUN: fa_a SHALL equal A shift register bit 0, fa_b B shift register bit 0, fa_cin carry register, combinationally.
REQ-020 RUN, each rising edge: shift fa_sum into sum register MSB (sum shifts right), carry register <= fa_cout, A/B shift right by one, counter increments.
REQ-021 RUN SHALL last exactly WIDTH cycles; on edge where counter reaches WIDTH-1 state goes to DONE.
REQ-022 DONE: done=1 for exactly one cycle, cout = carry register, sum = final LSB-first assembled result; next edge goes to IDLE unconditionally.
REQ-023 Latency: start accepted at edge E0 -> done high in cycle following edge E(WIDTH); busy high from E0 to E(WIDTH).
REQ-024 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-025 fa_a, fa_b, fa_cin SHALL be 0 outside RUN.
REQ-026 start in RUN or DONE SHALL be ignored (no capture, no queueing); operands changing during RUN SHALL not affect result.
REQ-027 start held high continuously SHALL produce back-to-back additions separated by one IDLE cycle.
REQ-028 sum and cout SHALL hold last result through IDLE; sum register contents during RUN are intermediate and not valid.
REQ-029 Result SHALL equal (op_a + op_b + cin) mod 2^WIDTH, cout = bit WIDTH of the full sum.
REQ-030 WIDTH=1: RUN lasts one cycle; done in cycle after E1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift registers=0, fa_* = 0, independent of clk.
REQ-032 Reset mid-RUN SHALL abort the addition; no done pulse; first start after release SHALL run a full WIDTH cycles.
REQ-033 After rst_n rises, first rising edge with start=1 SHALL be accepted.

Verification (WIDTH=8, bench models full adder combinationally)
REQ-034 op_a=8'h00, op_b=8'h00, cin=0, start one cycle -> busy 8 cycles, done in 9th cycle after E0, sum=8'h00, cout=0.
REQ-035 op_a=8'hFF, op_b=8'h01, cin=0 -> sum=8'h00, cout=1; op_a=8'hA5, op_b=8'h5A, cin=1 -> sum=8'h00, cout=1; op_a=8'h3C, op_b=8'h42, cin=0 -> sum=8'h7E, cout=0.
REQ-036 start pulsed again at cycle 3 of RUN with different operands -> ignored, first result unchanged, exactly one done.
REQ-037 rst_n low at cycle 4 of RUN -> outputs zero immediately, no done; new start 8'h10+8'h01 -> sum=8'h11, cout=0.
REQ-038 start held high, 1000 random op_a/op_b/cin -> each done matches REQ-029; spacing between done pulses exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. It feeds one bit pair per cycle, LSB first, to
// an external full adder. It collects the sum bits into a shift register and
// carries the full adder's carry-out into the next bit.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter needs at least one bit so that WIDTH=1 stays legal.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_shift;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_one
      assign sum_shift = fa_sum;
    end else begin : g_sum_many
      assign sum_shift = {fa_sum, sum_reg[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status/full-adder outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_cin     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = a_reg[0];
        fa_b   = b_reg[0];
        fa_cin = carry_reg;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on start, and one bit of addition per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_shift;
          carry_reg <= fa_cout;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          cnt_reg   <= cnt_reg + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // The carry register holds the final carry from the end of RUN until the next start.
  assign sum  = sum_reg;
  assign cout = carry_reg;

endmodule
